alu_operand_fetch: RTL

Operand-fetch stage directly upstream of the 16-bit ALU. It holds the general-purpose register file and sequences a multi-cycle read of Rn into pipeline register A, then Rm into pipeline register B. It applies the shifter and the A/B source selects, and presents a stable Ain/Bin pair with a one-cycle op_valid strobe. ALU results come back through a writeback port into the register file.

---
 rtl/alu_operand_fetch.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage ahead of the ALU: register file, two-cycle Rn/Rm read
// sequence with write-first bypass, B shifter and A/B source selects.
module alu_operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [DATA_W-1:0] sximm5,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_num,
  input  logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              op_valid,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin
);

  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_ISSUE
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [DATA_W-1:0]   r_regs [NREGS];
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [ADDR_W-1:0]   r_rn;
  logic [ADDR_W-1:0]   r_rm;
  logic [1:0]          r_shift;
  logic                r_asel;
  logic                r_bsel;
  logic [DATA_W-1:0]   r_sximm5;
  logic [DATA_W-1:0]   w_shiftedB;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b1;
    op_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_nextState = S_RD_A;
      end
      S_RD_A:  w_nextState = S_RD_B;
      S_RD_B:  w_nextState = S_ISSUE;
      S_ISSUE: begin
        op_valid    = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en) begin
      r_regs[wb_num] <= wb_data;
    end
  end

  // Controls are captured only on acceptance so Ain/Bin hold until the next op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rn     <= '0;
      r_rm     <= '0;
      r_shift  <= '0;
      r_asel   <= 1'b0;
      r_bsel   <= 1'b0;
      r_sximm5 <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_rn     <= rn;
      r_rm     <= rm;
      r_shift  <= shift;
      r_asel   <= asel;
      r_bsel   <= bsel;
      r_sximm5 <= sximm5;
    end
  end

  // Write-first: a same-edge writeback to the register being read wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (r_state == S_RD_A) begin
        r_a <= (wb_en && wb_num == r_rn) ? wb_data : r_regs[r_rn];
      end
      if (r_state == S_RD_B) begin
        r_b <= (wb_en && wb_num == r_rm) ? wb_data : r_regs[r_rm];
      end
    end
  end

  always_comb begin
    w_shiftedB = r_b;
    case (r_shift)
      2'b01:   w_shiftedB = {r_b[DATA_W-2:0], 1'b0};
      2'b10:   w_shiftedB = {1'b0, r_b[DATA_W-1:1]};
      2'b11:   w_shiftedB = {r_b[DATA_W-1], r_b[DATA_W-1:1]};
      default: w_shiftedB = r_b;
    endcase
  end

  assign Ain = r_asel ? '0 : r_a;
  assign Bin = r_bsel ? r_sximm5 : w_shiftedB;

endmodule
